// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared across the RISC-V pipeline.
//   - Architectural widths (XLEN, ILEN) and the canonical NOP encoding.
//   - Major opcode constants consumed by the control unit.
//   - fetch_entry_t: one fetched instruction together with its PC.
//   - word_align(): forces an address onto a 4-byte boundary.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_SBTYPE = 7'b110_0011;
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_ITYPE  = 7'b001_0011;
  localparam logic [6:0] OPC_RTYPE  = 7'b011_0011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fifo2.sv
// fifo2: two-entry FIFO with synchronous clear.
//   clk, reset_n   : clock, asynchronous active-low reset
//   clear          : empties the FIFO; overrides push and pop
//   push, push_data: write one entry at the tail
//   pop            : retire the head entry
//   count          : occupancy 0..2
//   head           : data at the head (entries reset to zero)
// A push while full is accepted only if a pop happens in the same cycle.
module fifo2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem0_q, mem0_d;
  logic [DATA_W-1:0] mem1_q, mem1_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push;
  logic              do_pop;

  always_comb begin
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);

    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (clear) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr_q) mem1_d = push_data;
        else          mem0_d = push_data;
        wr_ptr_d = ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_d = ~rd_ptr_q;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem0_q   <= mem0_d;
      mem1_q   <= mem1_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = rd_ptr_q ? mem1_q : mem0_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the RISC-V pipeline.
// Owns the PC, issues word requests to instruction memory, buffers the
// returned words with their PCs and hands them to decode.
//   clk, reset_n                  : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr     : request channel (fires on valid && ready)
//   imem_rsp_valid/data           : in-order response strobe, no backpressure
//   redirect_valid/redirect_pc    : flush younger state and restart fetch
//   id_valid/ready/instr/pc/opcode: decode slot (pops on valid && ready)
// Two credits are shared between requests in flight and buffered words, so
// every response always has a slot waiting for it. imem_req_valid depends
// combinationally on id_ready and redirect_valid: a pop frees a credit that
// is reused in the same cycle, which sustains one instruction per cycle.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode
);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]      outstanding_q, outstanding_d;
  logic [1:0]      drop_q, drop_d;

  logic [1:0]      pcq_count;
  logic [XLEN-1:0] pcq_head;
  logic [1:0]      buf_count;
  fetch_entry_t    buf_head;
  fetch_entry_t    buf_push_entry;

  logic [2:0]      occupancy;
  logic            pop;
  logic            fire;
  logic            rsp_keep;
  logic            rsp_drop;

  always_comb begin
    pop       = id_valid && id_ready && !redirect_valid;
    occupancy = {1'b0, outstanding_q} + {1'b0, buf_count};
    // Gating with reset_n keeps the request low while reset is held.
    imem_req_valid = reset_n && !redirect_valid
                     && ((occupancy < 3'd2) || pop)
                     && (pcq_count != 2'd2);
    fire     = imem_req_valid && imem_req_ready;
    rsp_keep = imem_rsp_valid && !redirect_valid && (drop_q == 2'd0);
    rsp_drop = imem_rsp_valid && !redirect_valid && (drop_q != 2'd0);
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;

    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      // Everything still in flight becomes stale; a response landing now
      // is discarded on the spot and no longer counts.
      outstanding_d = outstanding_q - {1'b0, imem_rsp_valid};
      drop_d        = outstanding_q - {1'b0, imem_rsp_valid};
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + 32'd4;
      unique case ({fire, imem_rsp_valid})
        2'b10:   outstanding_d = outstanding_q + 2'd1;
        2'b01:   outstanding_d = outstanding_q - 2'd1;
        default: outstanding_d = outstanding_q;
      endcase
      if (rsp_drop) drop_d = drop_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_q        <= 2'd0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // Addresses of live (non-stale) requests, oldest first.
  fifo2 #(.DATA_W(XLEN)) u_pc_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (redirect_valid),
    .push      (fire),
    .push_data (fetch_pc_q),
    .pop       (rsp_keep),
    .count     (pcq_count),
    .head      (pcq_head)
  );

  always_comb begin
    buf_push_entry.pc    = pcq_head;
    buf_push_entry.instr = imem_rsp_data;
  end

  fifo2 #(.DATA_W($bits(fetch_entry_t))) u_instr_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (redirect_valid),
    .push      (rsp_keep),
    .push_data (buf_push_entry),
    .pop       (pop),
    .count     (buf_count),
    .head      (buf_head)
  );

  assign imem_req_addr = fetch_pc_q;
  assign id_valid      = (buf_count != 2'd0);
  assign id_instr      = buf_head.instr;
  assign id_pc         = buf_head.pc;
  assign id_opcode     = buf_head.instr[6:0];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_opcode      (id_opcode)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F33;
  endfunction

  // Memory model: in-order requests with a due cycle.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  int    last_due;
  int    lat;
  bit    lat_rand;

  // Reference model: credit bookkeeping and the expected PC streams.
  int          cyc;
  int          inflight;
  int          buffered;
  int          stale;
  logic [31:0] exp_req;
  logic [31:0] exp_id;
  bit          hold;
  logic [31:0] hold_pc;

  // Snapshot of DUT outputs from the most recent step.
  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_id_valid;
  logic [31:0] s_id_pc;

  task automatic model_reset();
    mq.delete();
    last_due = -1;
    cyc      = 0;
    inflight = 0;
    buffered = 0;
    stale    = 0;
    exp_req  = 32'h0;
    exp_id   = 32'h0;
    hold     = 1'b0;
  endtask

  // Asserts reset mid-cycle, checks the asynchronous reset values, then
  // releases it just after a rising edge so the next step is cycle 0.
  task automatic do_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_opcode", {25'b0, id_opcode}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, sample and check, update model, advance.
  task automatic step(input bit rdr, input logic [31:0] rpc, input bit idr, input bit rqr);
    bit          pop, fire, rsp, exp_rv;
    int          l, due;
    logic [31:0] w;
    redirect_valid = rdr;
    redirect_pc    = rpc;
    id_ready       = idr;
    imem_req_ready = rqr;
    rsp            = (mq.size() != 0) && (mq[0].due == cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mq[0].addr) : 32'hDEAD_BEEF;
    #2;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_id_valid  = id_valid;
    s_id_pc     = id_pc;

    pop    = (buffered != 0) && idr && !rdr;
    exp_rv = !rdr && (((inflight + buffered) < 2) || pop);
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    if (exp_rv) chk("req_addr", imem_req_addr, exp_req);
    chk("id_valid", {31'b0, id_valid}, {31'b0, buffered != 0});
    if (hold) chk("hold_pc", id_pc, hold_pc);
    if (hold) chk("hold_instr", id_instr, mem_word(hold_pc));
    if (pop) begin
      w = mem_word(exp_id);
      chk("id_pc", id_pc, exp_id);
      chk("id_instr", id_instr, w);
      chk("id_opcode", {25'b0, id_opcode}, {25'b0, w[6:0]});
    end
    hold    = (buffered != 0) && !idr && !rdr;
    hold_pc = exp_id;
    fire    = exp_rv && rqr;

    if (rsp) void'(mq.pop_front());
    if (fire) begin
      l   = lat_rand ? int'($urandom_range(1, 4)) : lat;
      due = cyc + l;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: exp_req, due: due});
    end

    if (rdr) begin
      stale    = inflight - (rsp ? 1 : 0);
      inflight = stale;
      buffered = 0;
      exp_id   = {rpc[31:2], 2'b00};
      exp_req  = {rpc[31:2], 2'b00};
    end else begin
      if (pop) begin
        buffered--;
        exp_id = exp_id + 32'd4;
      end
      if (rsp) begin
        inflight--;
        if (stale > 0) stale--;
        else buffered++;
      end
      if (fire) begin
        inflight++;
        exp_req = exp_req + 32'd4;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  typedef struct {
    bit          idr;
    bit          rqr;
    bit          rv;
    logic [31:0] ra;
    bit          iv;
    logic [31:0] ipc;
  } vec_t;
  vec_t tbl[19];

  initial begin
    bit          found;
    logic [31:0] first_pc;

    // Streaming, decode stall of 5 cycles, then memory stall of 4 cycles.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h14};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h18};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 32'h1C, 1'b0, 32'h00};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 32'h1C, 1'b0, 32'h00};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b0, 32'h00};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b0, 32'h00};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 32'h24, 1'b1, 32'h1C};

    lat      = 1;
    lat_rand = 1'b0;
    model_reset();
    #1;
    do_reset();

    for (int i = 0; i < 19; i++) begin
      step(1'b0, 32'h0, tbl[i].idr, tbl[i].rqr);
      chk($sformatf("tbl%0d_req_valid", i), {31'b0, s_req_valid}, {31'b0, tbl[i].rv});
      chk($sformatf("tbl%0d_req_addr", i), s_req_addr, tbl[i].ra);
      chk($sformatf("tbl%0d_id_valid", i), {31'b0, s_id_valid}, {31'b0, tbl[i].iv});
      if (tbl[i].iv) chk($sformatf("tbl%0d_id_pc", i), s_id_pc, tbl[i].ipc);
    end

    // Redirect to 0x100 with two requests outstanding on a 3-cycle memory.
    do_reset();
    lat = 3;
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h100, 1'b1, 1'b1);
    chk("A_redirect_req_valid", {31'b0, s_req_valid}, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      if (s_req_valid) begin
        found = 1'b1;
        chk("A_first_req_addr", s_req_addr, 32'h100);
      end
    end
    chk("A_req_seen", {31'b0, found}, 32'h1);
    found = 1'b0;
    first_pc = 32'h0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      if (s_id_valid) begin
        found = 1'b1;
        first_pc = s_id_pc;
      end
    end
    chk("A_id_seen", {31'b0, found}, 32'h1);
    chk("A_first_id_pc", first_pc, 32'h100);

    // Redirect to 0x203 coinciding with a response and a decode pop.
    do_reset();
    lat = 1;
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h203, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("B_id_valid", {31'b0, s_id_valid}, 32'h0);
    chk("B_req_valid", {31'b0, s_req_valid}, 32'h1);
    chk("B_req_addr", s_req_addr, 32'h200);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Address wrap at the top of the address space.
    do_reset();
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("C_req_addr_top", s_req_addr, 32'hFFFF_FFFC);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("C_req_addr_wrap", s_req_addr, 32'h0000_0000);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Randomized traffic with variable latency, stalls, redirects and a
    // reset in the middle.
    do_reset();
    lat_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom_range(0, 19) == 0, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
